// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception-request path: source indices,
// FSM state encoding, cause codes and small selection helpers.
package cp0_pkg;

    localparam int unsigned NSRC    = 3;
    localparam int unsigned SRC_IDW = 2;

    typedef logic [SRC_IDW-1:0] src_id_t;
    typedef logic [NSRC-1:0]    src_vec_t;

    localparam src_id_t SRC_TIMER = 2'd0;
    localparam src_id_t SRC_UART  = 2'd1;
    localparam src_id_t SRC_EXT   = 2'd2;

    // Cause codes CP0 latches for each source.
    localparam logic [4:0] CAUSE_TIMER = 5'd1;
    localparam logic [4:0] CAUSE_UART  = 5'd3;
    localparam logic [4:0] CAUSE_EXT   = 5'd7;

    // Encodings are fixed so the state register matches the legacy layout.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2,
        ST_GAP     = 2'd3
    } exc_state_e;

    // One-hot vector for a source index; out-of-range indices give zero.
    function automatic src_vec_t src_onehot(input src_id_t id);
        src_vec_t r;
        r = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            r[i] = (id == SRC_IDW'(i));
        end
        return r;
    endfunction

    // Fixed priority: the highest-numbered set bit wins.
    function automatic src_id_t prio_pick(input src_vec_t v);
        src_id_t r;
        r = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (v[i]) begin
                r = SRC_IDW'(i);
            end
        end
        return r;
    endfunction

    // Cause code associated with a source index.
    function automatic logic [4:0] cause_of(input src_id_t id);
        logic [4:0] c;
        case (id)
            SRC_TIMER: c = CAUSE_TIMER;
            SRC_UART:  c = CAUSE_UART;
            SRC_EXT:   c = CAUSE_EXT;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one raw event line followed by a
// rising-edge detector producing a single-cycle pulse.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_raw,
    output logic irq_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw line through the synchroniser and remember the last synced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign irq_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/exc_request_ctrl.sv
// Exception-request controller: latches synchronised peripheral events as
// pending, raises one CP0 expSrc line by fixed priority, and tracks the
// source through acceptance and ERET. All outputs are registered.
module exc_request_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERET_GAP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] irq_in,
    input  logic [2:0] block_mask,
    input  logic       exp_block,
    input  logic       has_exp,
    input  logic       is_eret,
    input  logic       clr_lost,
    output logic [2:0] exp_src,
    output logic [2:0] pending,
    output logic [1:0] active_id,
    output logic       in_service,
    output logic [2:0] lost
);

    localparam int unsigned GAP_W = $clog2(ERET_GAP + 1);

    exc_state_e       state, state_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    src_vec_t         exp_src_nxt;
    src_id_t          active_id_nxt;
    logic             in_service_nxt;

    src_vec_t         edge_det;
    src_vec_t         svc_mask;
    src_vec_t         eligible;
    src_vec_t         eret_clr;
    src_vec_t         lost_set;
    logic             active_masked;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .rst     (rst),
            .irq_raw (irq_in[i]),
            .irq_rise(edge_det[i])
        );
    end

    // Derive eligibility, the ERET clear vector and newly lost events.
    always_comb begin
        svc_mask      = in_service ? src_onehot(active_id) : '0;
        eligible      = pending & ~block_mask & {NSRC{~exp_block}} & ~svc_mask;
        eret_clr      = ((state == ST_SERVICE) && is_eret) ? src_onehot(active_id) : '0;
        // A set coinciding with the ERET clear is a fresh event, not a lost one.
        lost_set      = edge_det & pending & ~eret_clr;
        active_masked = exp_block | (|(block_mask & src_onehot(active_id)));
    end

    // Next-state and next-output logic for the request FSM.
    always_comb begin
        state_nxt      = state;
        gap_nxt        = gap_cnt;
        exp_src_nxt    = exp_src;
        active_id_nxt  = active_id;
        in_service_nxt = in_service;
        case (state)
            ST_IDLE: begin
                if (|eligible) begin
                    active_id_nxt = prio_pick(eligible);
                    exp_src_nxt   = src_onehot(prio_pick(eligible));
                    state_nxt     = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (has_exp) begin
                    exp_src_nxt    = '0;
                    in_service_nxt = 1'b1;
                    state_nxt      = ST_SERVICE;
                end else if (active_masked) begin
                    exp_src_nxt = '0;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (is_eret) begin
                    in_service_nxt = 1'b0;
                    gap_nxt        = GAP_W'(ERET_GAP);
                    state_nxt      = ST_GAP;
                end
            end
            ST_GAP: begin
                // The decrement that reaches zero is also the exit edge, so
                // GAP lasts exactly ERET_GAP cycles.
                if (gap_cnt <= GAP_W'(1)) begin
                    gap_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_nxt      = ST_IDLE;
                gap_nxt        = '0;
                exp_src_nxt    = '0;
                in_service_nxt = 1'b0;
            end
        endcase
    end

    // Register FSM state and the request-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            exp_src    <= '0;
            active_id  <= '0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= gap_nxt;
            exp_src    <= exp_src_nxt;
            active_id  <= active_id_nxt;
            in_service <= in_service_nxt;
        end
    end

    // Track pending events (set beats ERET clear) and sticky lost flags (new event beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            lost    <= '0;
        end else begin
            pending <= (pending & ~eret_clr) | edge_det;
            lost    <= (lost & ~{NSRC{clr_lost}}) | lost_set;
        end
    end

endmodule

// File: tb/tb_exc_request_ctrl.sv
// Scoreboard bench for exc_request_ctrl: directed stimulus pushes the
// expected request (source, index, cause, exact cycle) and a negedge monitor
// pops and compares whenever a new request appears on exp_src.
module tb_exc_request_ctrl;
    import cp0_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] irq_in;
    logic [2:0] block_mask;
    logic       exp_block;
    logic       has_exp;
    logic       is_eret;
    logic       clr_lost;
    logic [2:0] exp_src;
    logic [2:0] pending;
    logic [1:0] active_id;
    logic       in_service;
    logic [2:0] lost;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0] src;
        logic [1:0] id;
        logic [4:0] cause;
        int         at;
    } exp_t;

    exp_t sbq[$];

    exc_request_ctrl #(
        .SYNC_STAGES(2),
        .ERET_GAP   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .block_mask(block_mask),
        .exp_block (exp_block),
        .has_exp   (has_exp),
        .is_eret   (is_eret),
        .clr_lost  (clr_lost),
        .exp_src   (exp_src),
        .pending   (pending),
        .active_id (active_id),
        .in_service(in_service),
        .lost      (lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [2:0] src, input logic [1:0] id,
                            input logic [4:0] cause, input int at);
        exp_t e;
        e.src = src; e.id = id; e.cause = cause; e.at = at;
        sbq.push_back(e);
    endtask

    // Raise the given lines for one cycle; returns just after edge E0.
    task automatic pulse(input logic [2:0] m);
        irq_in = m;
        tick(1);
        irq_in = '0;
    endtask

    task automatic accept();
        has_exp = 1'b1;
        tick(1);
        has_exp = 1'b0;
    endtask

    task automatic eret();
        is_eret = 1'b1;
        tick(1);
        is_eret = 1'b0;
    endtask

    // Monitor: one-hot invariant every cycle, scoreboard compare on each new request.
    initial begin
        logic [2:0] prev;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk);
            check("exp_src_onehot", ($countones(exp_src) <= 1), 1);
            if (exp_src != '0 && exp_src != prev) begin
                if (sbq.size() == 0) begin
                    check("unexpected_req", {29'd0, exp_src}, 0);
                end else begin
                    e = sbq.pop_front();
                    check("req_exp_src", {29'd0, exp_src}, {29'd0, e.src});
                    check("req_active_id", {30'd0, active_id}, {30'd0, e.id});
                    check("req_cause", {27'd0, cause_of(active_id)}, {27'd0, e.cause});
                    check("req_cycle", cyc, e.at);
                end
            end
            prev = exp_src;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; irq_in = '0; block_mask = '0; exp_block = 1'b0;
        has_exp = 1'b0; is_eret = 1'b0; clr_lost = 1'b0;
        tick(2);
        check("rst_exp_src", {29'd0, exp_src}, 0);
        check("rst_pending", {29'd0, pending}, 0);
        check("rst_lost", {29'd0, lost}, 0);
        check("rst_active_id", {30'd0, active_id}, 0);
        check("rst_in_service", {31'd0, in_service}, 0);
        rst = 1'b0;
        tick(2);

        // Single source: timer, then a UART event during service waits out the gap.
        push_req(3'b001, 2'd0, 5'd1, cyc + 4);
        pulse(3'b001);
        tick(2);
        check("s1_pending_e2", {29'd0, pending}, 3'b001);
        check("s1_no_req_e2", {29'd0, exp_src}, 0);
        tick(1);
        accept();
        check("s1_acc_exp_src", {29'd0, exp_src}, 0);
        check("s1_acc_in_service", {31'd0, in_service}, 1);
        check("s1_acc_active_id", {30'd0, active_id}, 0);
        pulse(3'b010);
        tick(2);
        check("s1_svc_pending", {29'd0, pending}, 3'b011);
        check("s1_svc_no_req", {29'd0, exp_src}, 0);
        push_req(3'b010, 2'd1, 5'd3, cyc + 3);
        eret();
        check("s1_eret_pending", {29'd0, pending}, 3'b010);
        check("s1_eret_in_service", {31'd0, in_service}, 0);
        tick(1);
        check("s1_gap_no_req", {29'd0, exp_src}, 0);
        tick(1);
        accept();
        eret();
        check("s1_done_pending", {29'd0, pending}, 0);

        // Priority: ext and timer together, ext first.
        push_req(3'b100, 2'd2, 5'd7, cyc + 4);
        pulse(3'b101);
        tick(3);
        accept();
        check("s2_in_service", {31'd0, in_service}, 1);
        push_req(3'b001, 2'd0, 5'd1, cyc + 3);
        eret();
        tick(2);
        accept();
        eret();
        check("s2_done_pending", {29'd0, pending}, 0);

        // Masking by block_mask, then exp_block withdrawing a live request.
        block_mask = 3'b010;
        pulse(3'b010);
        tick(5);
        check("s3_masked_no_req", {29'd0, exp_src}, 0);
        check("s3_masked_pending", {29'd0, pending}, 3'b010);
        block_mask = '0;
        push_req(3'b010, 2'd1, 5'd3, cyc + 1);
        tick(1);
        exp_block = 1'b1;
        tick(1);
        check("s3_withdraw_exp_src", {29'd0, exp_src}, 0);
        check("s3_withdraw_pending", {29'd0, pending}, 3'b010);
        check("s3_withdraw_in_service", {31'd0, in_service}, 0);
        tick(2);
        check("s3_blocked_no_req", {29'd0, exp_src}, 0);
        exp_block = 1'b0;
        push_req(3'b010, 2'd1, 5'd3, cyc + 1);
        tick(1);

        // Lost flag, clear, and clear racing a new lost event.
        pulse(3'b010);
        tick(1);
        check("s4_lost_e1", {29'd0, lost}, 0);
        tick(1);
        check("s4_lost_set", {29'd0, lost}, 3'b010);
        clr_lost = 1'b1; tick(1); clr_lost = 1'b0;
        check("s4_lost_cleared", {29'd0, lost}, 0);
        pulse(3'b010);
        tick(1);
        clr_lost = 1'b1; tick(1); clr_lost = 1'b0;
        check("s4_lost_race", {29'd0, lost}, 3'b010);
        clr_lost = 1'b1; tick(1); clr_lost = 1'b0;
        check("s4_lost_cleared2", {29'd0, lost}, 0);
        accept();
        check("s4_acc_in_service", {31'd0, in_service}, 1);
        pulse(3'b010);
        tick(1);
        push_req(3'b010, 2'd1, 5'd3, cyc + 3);
        eret();
        check("s4_eret_set_wins", {29'd0, pending}, 3'b010);
        check("s4_eret_no_lost", {29'd0, lost}, 0);
        check("s4_eret_in_service", {31'd0, in_service}, 0);
        tick(2);
        accept();
        eret();
        check("s4_done_pending", {29'd0, pending}, 0);
        tick(3);

        // Reset while ext request is on exp_src, then a clean request afterwards.
        push_req(3'b100, 2'd2, 5'd7, cyc + 4);
        pulse(3'b100);
        tick(3);
        check("s5_req_before_rst", {29'd0, exp_src}, 3'b100);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("s5_rst_exp_src", {29'd0, exp_src}, 0);
        check("s5_rst_pending", {29'd0, pending}, 0);
        check("s5_rst_lost", {29'd0, lost}, 0);
        check("s5_rst_active_id", {30'd0, active_id}, 0);
        check("s5_rst_in_service", {31'd0, in_service}, 0);
        push_req(3'b001, 2'd0, 5'd1, cyc + 4);
        pulse(3'b001);
        tick(3);
        accept();
        eret();
        check("s5_done_pending", {29'd0, pending}, 0);
        tick(4);

        check("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
